// File: rtl/mcu_spi_target.sv
// SPI mode-0 target for the companion MCU link: deframes transfers into a
// byte stream with per-target strobes and shifts reply bytes out on MISO.
module mcu_spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TARGET_OSD  = 8'd1,
  parameter logic [7:0] TARGET_HID  = 8'd2,
  parameter logic [7:0] TARGET_SDC  = 8'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_ss_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       mcu_start,
  output logic       mcu_osd_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_sdc_strobe,
  output logic [7:0] mcu_data,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_sdc_din
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_DATA = 2'd2} state_t;
  typedef enum logic [1:0] {TGT_NONE = 2'd0, TGT_OSD = 2'd1, TGT_HID = 2'd2, TGT_SDC = 2'd3} target_t;

  function automatic target_t decode_target(input logic [7:0] cmd);
    target_t tgt;
    case (cmd)
      TARGET_OSD: tgt = TGT_OSD;
      TARGET_HID: tgt = TGT_HID;
      TARGET_SDC: tgt = TGT_SDC;
      default:    tgt = TGT_NONE;
    endcase
    return tgt;
  endfunction

  logic [SYNC_STAGES-1:0] ss_sync_r, sclk_sync_r, mosi_sync_r;
  logic       ss_prev_r, sclk_prev_r;
  logic       ss_s, sclk_s, mosi_s, sclk_rise_s, sclk_fall_s, ss_fall_s;
  logic       byte_rise_s, byte_done_s;
  state_t     state_r, state_s;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r, tx_r, data_r, reply_s;
  logic       done_r, done_cmd_r, first_r, skip_r;
  logic       osd_r, hid_r, sdc_r, start_r;
  target_t    target_r, reply_tgt_s;

  assign ss_s        = ss_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_s & sclk_prev_r;
  assign ss_fall_s   = ~ss_s & ss_prev_r;
  assign byte_rise_s = sclk_rise_s & (state_r != ST_IDLE);
  assign byte_done_s = byte_rise_s & (bit_cnt_r == 3'd7);
  // The reply for the byte just finished uses the target it may have just selected
  assign reply_tgt_s = done_cmd_r ? decode_target(shift_r) : target_r;

  assign spi_miso       = tx_r[7];
  assign mcu_start      = start_r;
  assign mcu_osd_strobe = osd_r;
  assign mcu_hid_strobe = hid_r;
  assign mcu_sdc_strobe = sdc_r;
  assign mcu_data       = data_r;

  // Input synchronizers and one-cycle history for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync_r   <= {SYNC_STAGES{1'b0}};
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      ss_prev_r   <= 1'b0;
      sclk_prev_r <= 1'b0;
    end else begin
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], spi_ss_n};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      ss_prev_r   <= ss_s;
      sclk_prev_r <= sclk_s;
    end
  end

  // Frame state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ss_fall_s) state_s = ST_CMD;
        else           state_s = ST_IDLE;
      end
      ST_CMD: begin
        if (ss_s)             state_s = ST_IDLE;
        else if (byte_done_s) state_s = ST_DATA;
        else                  state_s = ST_CMD;
      end
      ST_DATA: begin
        if (ss_s) state_s = ST_IDLE;
        else      state_s = ST_DATA;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Reply byte selection
  always_comb begin
    reply_s = 8'h00;
    case (reply_tgt_s)
      TGT_HID: reply_s = mcu_hid_din;
      TGT_SDC: reply_s = mcu_sdc_din;
      default: reply_s = 8'h00;
    endcase
  end

  // Receive shifter and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      done_r     <= 1'b0;
      done_cmd_r <= 1'b0;
    end else begin
      if (state_r == ST_IDLE || ss_s) begin
        bit_cnt_r <= 3'd0;
      end else if (byte_rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (byte_rise_s) begin
        shift_r <= {shift_r[6:0], mosi_s};
      end
      done_r     <= byte_done_s;
      done_cmd_r <= (state_r == ST_CMD);
    end
  end

  // Byte delivery: data, target latch and single-cycle strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r   <= 8'h00;
      target_r <= TGT_NONE;
      first_r  <= 1'b0;
      osd_r    <= 1'b0;
      hid_r    <= 1'b0;
      sdc_r    <= 1'b0;
      start_r  <= 1'b0;
    end else begin
      osd_r   <= 1'b0;
      hid_r   <= 1'b0;
      sdc_r   <= 1'b0;
      start_r <= 1'b0;
      if (done_r) begin
        data_r <= shift_r;
        if (done_cmd_r) begin
          target_r <= decode_target(shift_r);
          first_r  <= 1'b1;
        end else begin
          osd_r   <= (target_r == TGT_OSD);
          hid_r   <= (target_r == TGT_HID);
          sdc_r   <= (target_r == TGT_SDC);
          start_r <= first_r & (target_r != TGT_NONE);
          first_r <= 1'b0;
        end
      end
    end
  end

  // MISO shifter; the fall right after a load is skipped so the new MSB is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_r   <= 8'h00;
      skip_r <= 1'b0;
    end else begin
      if (state_r == ST_IDLE || ss_s) begin
        tx_r   <= 8'h00;
        skip_r <= 1'b0;
      end else if (done_r) begin
        tx_r   <= reply_s;
        skip_r <= 1'b1;
      end else if (sclk_fall_s) begin
        if (skip_r) skip_r <= 1'b0;
        else        tx_r   <= {tx_r[6:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed and randomized frames for mcu_spi_target, checked against a
// frame-level model of expected strobes, data, latency and MISO bytes.
module tb_mcu_spi_target;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset, ss_n, sclk, mosi;
  logic       miso, start, osd, hid, sdc;
  logic [7:0] data, hid_din, sdc_din;

  mcu_spi_target #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .spi_ss_n(ss_n), .spi_sclk(sclk), .spi_mosi(mosi),
    .spi_miso(miso), .mcu_start(start), .mcu_osd_strobe(osd),
    .mcu_hid_strobe(hid), .mcu_sdc_strobe(sdc), .mcu_data(data),
    .mcu_hid_din(hid_din), .mcu_sdc_din(sdc_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] strb;
    logic [7:0] data;
    logic       start;
  } ev_t;

  ev_t act_ev[$];
  int  act_cyc[$];

  // Record every cycle in which any strobe or start is high
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (osd | hid | sdc | start) begin
      e.strb  = {osd, hid, sdc};
      e.data  = data;
      e.start = start;
      act_ev.push_back(e);
      act_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] byte_q[$];
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input int h, input bit ss_last,
                           output logic [7:0] mb, output int rc);
    mb = 8'h00;
    rc = 0;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      repeat (h) @(negedge clk);
      mb[7-i] = miso;
      sclk = 1'b1;
      if (i == 7) begin
        rc = cyc;
        if (ss_last) ss_n = 1'b1;
      end
      repeat (h) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int h, input int gap_max, input int part_bits,
                           input logic [7:0] part_val, input bit ss_at_end);
    logic [7:0] miso_q[$];
    int         rise_q[$];
    logic [7:0] mb, tgt, reply;
    logic [2:0] exp_strb;
    int         rc, exp_n;
    bit         known, last;
    act_ev.delete();
    act_cyc.delete();
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    foreach (byte_q[i]) begin
      last = ss_at_end && (i == byte_q.size() - 1) && (part_bits == 0);
      send_bits(byte_q[i], 8, h, last, mb, rc);
      miso_q.push_back(mb);
      rise_q.push_back(rc);
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    end
    if (part_bits > 0) send_bits(part_val, part_bits, h, 1'b0, mb, rc);
    repeat (3) @(negedge clk);
    ss_n = 1'b1;
    repeat (SYNC + 8) @(negedge clk);

    tgt      = byte_q[0];
    known    = tgt inside {8'd1, 8'd2, 8'd3};
    exp_n    = known ? byte_q.size() - 1 : 0;
    exp_strb = (tgt == 8'd1) ? 3'b100 : (tgt == 8'd2) ? 3'b010 : 3'b001;
    reply    = (tgt == 8'd2) ? hid_din : (tgt == 8'd3) ? sdc_din : 8'h00;
    check("event_count", act_ev.size(), exp_n);
    for (int i = 1; i < byte_q.size(); i++) begin
      if (known && act_ev.size() >= i) begin
        check("strobe_sel", 32'(act_ev[i-1].strb), 32'(exp_strb));
        check("strobe_data", 32'(act_ev[i-1].data), 32'(byte_q[i]));
        check("start_flag", 32'(act_ev[i-1].start), (i == 1) ? 32'd1 : 32'd0);
        check("latency", act_cyc[i-1] - rise_q[i], SYNC + 2);
      end
    end
    exp_data = byte_q[byte_q.size() - 1];
    check("mcu_data", 32'(data), 32'(exp_data));
    if (h >= 4) begin
      foreach (miso_q[i]) check("miso_byte", 32'(miso_q[i]), (i == 0) ? 32'd0 : 32'(reply));
    end
    check("miso_idle", 32'(miso), 32'd0);
  endtask

  initial begin
    logic [7:0] mb;
    int         rc, len, r;
    reset = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    hid_din = 8'h00; sdc_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'd0);
    check("rst_strobes", 32'({osd, hid, sdc, start}), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    byte_q = '{8'h01, 8'hA5, 8'h3C, 8'h7E};
    run_frame(4, 0, 0, 8'h00, 1'b0);

    hid_din = 8'h5A;
    byte_q = '{8'h02, 8'h11, 8'h22};
    run_frame(4, 3, 0, 8'h00, 1'b0);

    sdc_din = 8'h96;
    byte_q = '{8'h09, 8'hFF};
    run_frame(4, 2, 0, 8'h00, 1'b0);

    byte_q = '{8'h03};
    run_frame(4, 0, 5, 8'hC3, 1'b0);
    byte_q = '{8'h03, 8'hC3};
    run_frame(4, 0, 0, 8'h00, 1'b0);

    // select released in the same cycle as the last byte's 8th rise
    byte_q = '{8'h01, 8'h5A};
    run_frame(4, 0, 0, 8'h00, 1'b1);

    for (int f = 0; f < 8; f++) begin
      r       = $urandom_range(3, 0);
      hid_din = 8'($urandom_range(255, 0));
      sdc_din = 8'($urandom_range(255, 0));
      len     = $urandom_range(4, 1);
      byte_q.delete();
      byte_q.push_back((r == 0) ? 8'($urandom_range(255, 4)) : 8'(r));
      for (int k = 0; k < len; k++) byte_q.push_back(8'($urandom_range(255, 0)));
      run_frame(($urandom_range(1, 0) == 1) ? 2 : 4, 5, 0, 8'h00, 1'b0);
    end

    // reset during byte 2 of an OSD frame
    act_ev.delete();
    act_cyc.delete();
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(8'h01, 8, 4, 1'b0, mb, rc);
    send_bits(8'hA5, 8, 4, 1'b0, mb, rc);
    send_bits(8'h3C, 3, 4, 1'b0, mb, rc);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_strobes", 32'({osd, hid, sdc, start}), 32'd0);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_prior_ev", act_ev.size(), 1);
    @(negedge clk);
    reset = 1'b0;
    send_bits(8'h55, 8, 4, 1'b0, mb, rc);
    send_bits(8'hAA, 8, 4, 1'b0, mb, rc);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    check("postrst_ignored_ev", act_ev.size(), 1);
    check("postrst_data", 32'(data), 32'd0);
    byte_q = '{8'h01, 8'h77, 8'h88};
    run_frame(2, 2, 0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
